// File: rtl/stream_saturator.sv
// Pipelined saturating limiter: optional arithmetic right shift with rounding, clamp to run-time
// limits, one register stage on a valid/ready stream, plus saturation statistics.
module stream_saturator #(
    parameter int WIDTH_IN  = 32,
    parameter int WIDTH_OUT = 24,
    parameter int SHIFT_W   = 5,
    parameter int ROUND     = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH_IN-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic [WIDTH_OUT-1:0] lim_hi,
    input  logic [WIDTH_OUT-1:0] lim_lo,
    input  logic                 clr_stats,
    output logic [WIDTH_OUT-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sat_hi,
    output logic                 out_sat_lo,
    output logic [CNT_W-1:0]     sat_hi_count,
    output logic [CNT_W-1:0]     sat_lo_count,
    output logic                 sat_hi_seen,
    output logic                 sat_lo_seen,
    output logic                 cfg_err
);

    // One guard bit keeps the rounding add from overflowing.
    localparam int WX = WIDTH_IN + 1;
    localparam logic [WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic [WIDTH_OUT-1:0] OUT_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};

    logic signed [WX-1:0]  ext_s, rnd_s, x_s, hi_s, lo_s;
    logic [WIDTH_OUT-1:0]  hi_o, lo_o;
    logic                  cfg_bad, clamp_hi, clamp_lo, accept;

    logic [WIDTH_OUT-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]      hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
    logic                  hi_seen_q, hi_seen_d, lo_seen_q, lo_seen_d;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        ext_s = {in_data[WIDTH_IN-1], in_data};
        rnd_s = '0;
        if (ROUND != 0 && shift != '0) begin
            rnd_s = WX'(1) << (shift - SHIFT_W'(1));
        end
        x_s = (ext_s + rnd_s) >>> shift;

        // Inverted limits fall back to the full output range rather than producing garbage.
        cfg_bad = $signed(lim_lo) > $signed(lim_hi);
        hi_o    = cfg_bad ? OUT_MAX : lim_hi;
        lo_o    = cfg_bad ? OUT_MIN : lim_lo;
        hi_s    = {{(WX-WIDTH_OUT){hi_o[WIDTH_OUT-1]}}, hi_o};
        lo_s    = {{(WX-WIDTH_OUT){lo_o[WIDTH_OUT-1]}}, lo_o};

        clamp_hi = x_s > hi_s;
        clamp_lo = !clamp_hi && (x_s < lo_s);
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        sat_hi_d  = sat_hi_q;
        sat_lo_d  = sat_lo_q;
        cfg_err_d = cfg_err_q;
        if (accept) begin
            valid_d   = 1'b1;
            sat_hi_d  = clamp_hi;
            sat_lo_d  = clamp_lo;
            cfg_err_d = cfg_bad;
            if (clamp_hi) begin
                data_d = hi_o;
            end else if (clamp_lo) begin
                data_d = lo_o;
            end else begin
                data_d = x_s[WIDTH_OUT-1:0];
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Clear wins over a coincident clamp event.
    always_comb begin
        hi_cnt_d  = hi_cnt_q;
        lo_cnt_d  = lo_cnt_q;
        hi_seen_d = hi_seen_q;
        lo_seen_d = lo_seen_q;
        if (clr_stats) begin
            hi_cnt_d  = '0;
            lo_cnt_d  = '0;
            hi_seen_d = 1'b0;
            lo_seen_d = 1'b0;
        end else if (accept) begin
            if (clamp_hi) begin
                hi_seen_d = 1'b1;
                if (!(&hi_cnt_q)) hi_cnt_d = hi_cnt_q + CNT_W'(1);
            end
            if (clamp_lo) begin
                lo_seen_d = 1'b1;
                if (!(&lo_cnt_q)) lo_cnt_d = lo_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            sat_hi_q  <= 1'b0;
            sat_lo_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            hi_cnt_q  <= '0;
            lo_cnt_q  <= '0;
            hi_seen_q <= 1'b0;
            lo_seen_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            sat_hi_q  <= sat_hi_d;
            sat_lo_q  <= sat_lo_d;
            cfg_err_q <= cfg_err_d;
            hi_cnt_q  <= hi_cnt_d;
            lo_cnt_q  <= lo_cnt_d;
            hi_seen_q <= hi_seen_d;
            lo_seen_q <= lo_seen_d;
        end
    end

    assign out_data     = data_q;
    assign out_valid    = valid_q;
    assign out_sat_hi   = sat_hi_q;
    assign out_sat_lo   = sat_lo_q;
    assign cfg_err      = cfg_err_q;
    assign sat_hi_count = hi_cnt_q;
    assign sat_lo_count = lo_cnt_q;
    assign sat_hi_seen  = hi_seen_q;
    assign sat_lo_seen  = lo_seen_q;

endmodule

// File: doc/stream_saturator.md
Name: stream_saturator

Overview:
- Parametrised, pipelined saturating limiter for the signed sample path.
- Accepts WIDTH_IN-bit signed samples on a valid/ready stream, applies an optional arithmetic right shift with optional rounding, clamps to run-time limits, and emits WIDTH_OUT-bit signed samples.
- Sits between the DSP accumulators and the output/DAC stage.
- Counts and flags saturation events for software monitoring.

Parameters:
- WIDTH_IN, 32, input sample width (signed two's complement).
- WIDTH_OUT, 24, output sample width and limit width (signed); requires WIDTH_OUT <= WIDTH_IN.
- SHIFT_W, 5, width of shift control.
- ROUND, 1, 0 = truncate on shift; 1 = round half up (add 2^(shift-1) before shifting when shift > 0).
- CNT_W, 16, width of each saturation event counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous reset, active high
- in_data  input  WIDTH_IN  signed input sample
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample this cycle
- shift  input  SHIFT_W  arithmetic right-shift amount, sampled per accepted beat
- lim_hi  input  WIDTH_OUT  signed upper limit, sampled per accepted beat
- lim_lo  input  WIDTH_OUT  signed lower limit, sampled per accepted beat
- clr_stats  input  1  single-cycle pulse: zero counters and sticky flags
- out_data  output  WIDTH_OUT  signed limited sample
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_sat_hi  output  1  current output beat was clamped high
- out_sat_lo  output  1  current output beat was clamped low
- sat_hi_count  output  CNT_W  count of high-clamp beats, saturating
- sat_lo_count  output  CNT_W  count of low-clamp beats, saturating
- sat_hi_seen  output  1  sticky: any high clamp since last clear
- sat_lo_seen  output  1  sticky: any low clamp since last clear
- cfg_err  output  1  registered: last accepted beat had lim_lo > lim_hi

Behaviour:
- Reset (async assert; release is synchronised by the system reset controller): all outputs 0, including out_valid, flags, counters and cfg_err.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, a combinational path from out_ready.
  - Output beat transfers when out_valid && out_ready.
  - While out_valid && !out_ready: out_data, out_sat_hi/lo and out_valid hold stable.
  - Latency: exactly 1 cycle from acceptance to out_valid.
  - Throughput: 1 beat/cycle while out_ready is high.
  - out_valid clears after a transfer with no new acceptance in the same cycle.
- Arithmetic, per accepted beat; all intermediate values are signed, WIDTH_IN+1 bits wide, so there is no internal overflow:
  - s = shift (any value 0..2^SHIFT_W-1; shift >= WIDTH_IN yields 0 or -1).
  - If ROUND = 1 and s > 0: x = (in_data + 2^(s-1)) >>> s; otherwise x = in_data >>> s.
  - Effective limits:
    - If lim_lo <= lim_hi: hi = lim_hi, lo = lim_lo.
    - Otherwise: hi = +2^(WIDTH_OUT-1)-1, lo = -2^(WIDTH_OUT-1), and cfg_err = 1 for that beat.
  - x > hi: out = hi, sat_hi = 1.
  - x < lo: out = lo, sat_lo = 1.
  - Otherwise out = x[WIDTH_OUT-1:0].
  - x == hi or x == lo: not saturated, no flag.
  - sat_hi and sat_lo are never both set.
- Statistics:
  - Counters increment on acceptance of a clamped beat, not on output transfer.
  - Counters stop at 2^CNT_W-1; they do not wrap.
  - Sticky flags set alongside the counter increment.
  - clr_stats zeroes counters and sticky flags next edge. A clamp event in the same cycle as clr_stats is discarded (clear wins).
  - clr_stats does not affect the data path, out_valid or cfg_err.
- cfg_err updates only on accepted beats; it holds otherwise.
- Reset mid-stream: the in-flight beat is dropped and out_valid = 0 immediately on assertion.

Test Plan:
- WIDTH_IN=32, WIDTH_OUT=24, shift=0, lim_hi=7000000, lim_lo=-7000000, out_ready=1:
  - in 7000001 -> out 7000000, out_sat_hi=1, sat_hi_count=1.
  - in -7000001 -> out -7000000, out_sat_lo=1.
  - in 7000000 -> out 7000000, no flag.
  - Each output appears 1 cycle after acceptance.
- Shift/round:
  - shift=2, ROUND=1: in 6 -> out 2; in -6 -> out -1; in 5 -> out 1.
  - ROUND=0: in -6 -> out -2.
  - in 32'h7FFFFFFF, shift=0, full-range limits -> out 8388607, sat_hi.
- Backpressure:
  - Stream 1,2,3,4 with out_ready pattern 1,0,0,1,1,1 -> output order 1,2,3,4; data held stable while stalled; in_ready low while out_valid && !out_ready; no loss or duplication.
- Bad config:
  - lim_lo=100, lim_hi=-100, in 9000000 -> cfg_err=1, out 8388607, sat_hi=1.
  - Next beat with lim_lo=-100, lim_hi=100 -> cfg_err=0.
- Counters:
  - CNT_W=2, 5 high clamps -> sat_hi_count stops at 3.
  - clr_stats coincident with a 6th clamp -> count 0, sat_hi_seen 0.
- Async reset:
  - Assert rst_in mid-cycle with out_valid=1 -> out_valid, out_data and counters go to 0 before the next clock edge.
  - After release, the first accepted beat is processed normally.
